// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus widths, payload layouts,
// load one-hot and exception vector bit positions.
package mem_stage_pkg;

   localparam int unsigned EXC_NUM         = 7;
   localparam int unsigned LD_NUM          = 5;
   localparam int unsigned ES_RF_COLLECT_W = 39;
   localparam int unsigned MS_TO_WS_W      = 77;
   localparam int unsigned MS_RF_COLLECT_W = 38;

   // Load one-hot {ld_b, ld_bu, ld_h, ld_hu, ld_w}
   localparam int unsigned LD_B  = 4;
   localparam int unsigned LD_BU = 3;
   localparam int unsigned LD_H  = 2;
   localparam int unsigned LD_HU = 1;
   localparam int unsigned LD_W  = 0;

   // Exception vector {ale, 6 decode-stage bits}
   localparam int unsigned EXC_ALE    = 6;
   localparam int unsigned EXC_DS_MSB = 5;
   localparam int unsigned EXC_DS_LSB = 0;

   typedef struct packed {
      logic        res_from_mem;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] result;
   } es_rf_collect_t;

   typedef struct packed {
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] result;
   } ms_rf_collect_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load alignment: selects byte/half/word from the read data by
// byte offset and sign- or zero-extends according to the load one-hot.
module load_align
   import mem_stage_pkg::*;
(
   input  logic [31:0]       rdata_i,
   input  logic [1:0]        off_i,
   input  logic [LD_NUM-1:0] ld_i,
   output logic [31:0]       result_o
);

   logic [31:0] shifted;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   assign shifted = rdata_i >> {off_i, 3'b000};
   assign byte_v  = shifted[7:0];
   assign half_v  = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

   // Plain if-chain: non-load payloads carry an all-zero one-hot.
   always_comb begin
      result_o = '0;
      if (ld_i[LD_B]) begin
         result_o = {{24{byte_v[7]}}, byte_v};
      end else if (ld_i[LD_BU]) begin
         result_o = {24'b0, byte_v};
      end else if (ld_i[LD_H]) begin
         result_o = {{16{half_v[15]}}, half_v};
      end else if (ld_i[LD_HU]) begin
         result_o = {16'b0, half_v};
      end else if (ld_i[LD_W]) begin
         result_o = rdata_i;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the execute payload, captures SRAM
// read data in the first cycle, aligns loads and hands off to write-back.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned EXC_W = 7,
   parameter int unsigned LD_W  = 5
) (
   input  logic                       clk,
   input  logic                       resetn,
   output logic                       ms_allowin,
   input  logic                       es_to_ms_valid,
   input  logic [ES_RF_COLLECT_W-1:0] es_rf_collect,
   input  logic [31:0]                es_pc,
   input  logic [LD_W-1:0]            es_mem_inst_bus,
   input  logic [EXC_W-1:0]           es_to_ms_bus,
   input  logic [31:0]                data_sram_rdata,
   input  logic                       ws_allowin,
   input  logic                       wb_flush,
   output logic                       ms_to_ws_valid,
   output logic [EXC_W+69:0]          ms_to_ws_bus,
   output logic [MS_RF_COLLECT_W-1:0] ms_rf_collect,
   output logic                       ms_ex
);

   logic           ms_valid_q, ms_valid_d;
   es_rf_collect_t rf_q, rf_d;
   logic [31:0]    pc_q, pc_d;
   logic [LD_W-1:0]  ld_q, ld_d;
   logic [EXC_W-1:0] exc_q, exc_d;
   logic [31:0]    rdata_buf_q, rdata_buf_d;
   logic           first_cyc_q, first_cyc_d;

   logic           accept;
   logic [31:0]    rdata_eff;
   logic [31:0]    load_result;
   logic [31:0]    final_result;
   logic           has_exc;
   logic           rf_we_eff;
   ms_rf_collect_t fwd;

   assign ms_allowin = ~ms_valid_q | ws_allowin;
   assign accept     = es_to_ms_valid & ms_allowin & ~wb_flush;

   always_comb begin
      ms_valid_d  = ms_valid_q;
      rf_d        = rf_q;
      pc_d        = pc_q;
      ld_d        = ld_q;
      exc_d       = exc_q;
      first_cyc_d = accept;
      // SRAM data is only valid in the first cycle; keep it for stalls.
      rdata_buf_d = first_cyc_q ? data_sram_rdata : rdata_buf_q;
      if (wb_flush) begin
         ms_valid_d = 1'b0;
      end else if (ms_allowin) begin
         ms_valid_d = es_to_ms_valid;
      end
      if (accept) begin
         rf_d  = es_rf_collect;
         pc_d  = es_pc;
         ld_d  = es_mem_inst_bus;
         exc_d = es_to_ms_bus;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ms_valid_q  <= 1'b0;
         rf_q        <= '0;
         pc_q        <= '0;
         ld_q        <= '0;
         exc_q       <= '0;
         rdata_buf_q <= '0;
         first_cyc_q <= 1'b0;
      end else begin
         ms_valid_q  <= ms_valid_d;
         rf_q        <= rf_d;
         pc_q        <= pc_d;
         ld_q        <= ld_d;
         exc_q       <= exc_d;
         rdata_buf_q <= rdata_buf_d;
         first_cyc_q <= first_cyc_d;
      end
   end

   assign rdata_eff = first_cyc_q ? data_sram_rdata : rdata_buf_q;

   load_align u_load_align (
      .rdata_i  (rdata_eff),
      .off_i    (rf_q.result[1:0]),
      .ld_i     (ld_q),
      .result_o (load_result)
   );

   assign final_result = rf_q.res_from_mem ? load_result : rf_q.result;
   assign has_exc      = |exc_q;
   assign rf_we_eff    = rf_q.rf_we & ~has_exc;

   assign fwd.rf_we    = rf_we_eff & ms_valid_q;
   assign fwd.rf_waddr = rf_q.rf_waddr;
   assign fwd.result   = final_result;

   assign ms_to_ws_valid = ms_valid_q & ~wb_flush;
   assign ms_to_ws_bus   = {exc_q, pc_q, rf_we_eff, rf_q.rf_waddr, final_result};
   assign ms_rf_collect  = fwd;
   assign ms_ex          = ms_valid_q & has_exc;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: cycle-level reference model compared every
// cycle, plus directed cases with literal expectations.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic         clk = 1'b0;
   logic         resetn = 1'b1;
   logic         ms_allowin;
   logic         es_to_ms_valid;
   logic [38:0]  es_rf_collect;
   logic [31:0]  es_pc;
   logic [4:0]   es_mem_inst_bus;
   logic [6:0]   es_to_ms_bus;
   logic [31:0]  data_sram_rdata;
   logic         ws_allowin;
   logic         wb_flush;
   logic         ms_to_ws_valid;
   logic [76:0]  ms_to_ws_bus;
   logic [37:0]  ms_rf_collect;
   logic         ms_ex;

   int unsigned  n_chk = 0;
   int unsigned  n_fail = 0;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk             (clk),
      .resetn          (resetn),
      .ms_allowin      (ms_allowin),
      .es_to_ms_valid  (es_to_ms_valid),
      .es_rf_collect   (es_rf_collect),
      .es_pc           (es_pc),
      .es_mem_inst_bus (es_mem_inst_bus),
      .es_to_ms_bus    (es_to_ms_bus),
      .data_sram_rdata (data_sram_rdata),
      .ws_allowin      (ws_allowin),
      .wb_flush        (wb_flush),
      .ms_to_ws_valid  (ms_to_ws_valid),
      .ms_to_ws_bus    (ms_to_ws_bus),
      .ms_rf_collect   (ms_rf_collect),
      .ms_ex           (ms_ex)
   );

   // Reference load semantics from plain arithmetic.
   function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [1:0] off,
                                            input logic [4:0] ld);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(d >> (32'(off) * 8));
      h = 16'(d >> (32'(off[1]) * 16));
      if (ld[LD_B])       return 32'($signed(b));
      else if (ld[LD_BU]) return 32'(b);
      else if (ld[LD_H])  return 32'($signed(h));
      else if (ld[LD_HU]) return 32'(h);
      else if (ld[LD_W])  return d;
      return 32'd0;
   endfunction

   // Model: what instruction sits in the stage and the data it saw on arrival.
   logic        m_valid, m_first, m_rfm, m_we;
   logic [4:0]  m_waddr, m_ld;
   logic [31:0] m_res, m_pc, m_data;
   logic [6:0]  m_exc;

   logic        e_allow, m_acc, e_we;
   logic [31:0] e_data, e_final;
   logic [76:0] e_bus;
   logic [37:0] e_fwd;

   assign e_allow = ~m_valid | ws_allowin;
   assign m_acc   = es_to_ms_valid & e_allow & ~wb_flush;
   assign e_data  = m_first ? data_sram_rdata : m_data;
   assign e_final = m_rfm ? ref_load(e_data, m_res[1:0], m_ld) : m_res;
   assign e_we    = m_we & (m_exc == 7'd0);
   assign e_bus   = {m_exc, m_pc, e_we, m_waddr, e_final};
   assign e_fwd   = {e_we & m_valid, m_waddr, e_final};

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_valid <= 1'b0; m_first <= 1'b0; m_rfm <= 1'b0; m_we <= 1'b0;
         m_waddr <= '0; m_ld <= '0; m_res <= '0; m_pc <= '0; m_data <= '0; m_exc <= '0;
      end else begin
         if (m_first) m_data <= data_sram_rdata;
         m_first <= m_acc;
         if (m_acc) begin
            {m_rfm, m_we, m_waddr, m_res} <= es_rf_collect;
            m_pc  <= es_pc;
            m_ld  <= es_mem_inst_bus;
            m_exc <= es_to_ms_bus;
         end
         if (wb_flush) m_valid <= 1'b0;
         else if (e_allow) m_valid <= es_to_ms_valid;
      end
   end

   // Literal expectations requested by the directed sequence.
   localparam int L_RES = 0, L_EX = 1, L_WE = 2, L_VLD = 3, L_ALW = 4, L_ZERO = 5;
   logic [5:0]  lit_chk = '0;
   logic [31:0] lit_res;
   logic        lit_ex, lit_we, lit_vld, lit_alw;

   task automatic chk(input string name, input logic [76:0] act, input logic [76:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("ms_allowin", 77'(ms_allowin), 77'(e_allow));
      chk("ms_to_ws_valid", 77'(ms_to_ws_valid), 77'(m_valid & ~wb_flush));
      chk("ms_ex", 77'(ms_ex), 77'(m_valid & (m_exc != 7'd0)));
      chk("ms_to_ws_bus", ms_to_ws_bus, e_bus);
      chk("ms_rf_collect", 77'(ms_rf_collect), 77'(e_fwd));
      if (lit_chk[L_RES])  chk("lit_result", 77'(ms_to_ws_bus[31:0]), 77'(lit_res));
      if (lit_chk[L_EX])   chk("lit_ms_ex", 77'(ms_ex), 77'(lit_ex));
      if (lit_chk[L_WE]) begin
         chk("lit_bus_we", 77'(ms_to_ws_bus[37]), 77'(lit_we));
         chk("lit_fwd_we", 77'(ms_rf_collect[37]), 77'(lit_we));
      end
      if (lit_chk[L_VLD])  chk("lit_valid", 77'(ms_to_ws_valid), 77'(lit_vld));
      if (lit_chk[L_ALW])  chk("lit_allowin", 77'(ms_allowin), 77'(lit_alw));
      if (lit_chk[L_ZERO]) begin
         chk("lit_bus_zero", ms_to_ws_bus, 77'd0);
         chk("lit_fwd_zero", 77'(ms_rf_collect), 77'd0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic vld, input logic rfm, input logic we, input logic [4:0] wa,
                        input logic [31:0] res, input logic [4:0] ld, input logic [6:0] exc);
      es_to_ms_valid  = vld;
      es_rf_collect   = {rfm, we, wa, res};
      es_pc           = 32'h1c00_0000 + res;
      es_mem_inst_bus = ld;
      es_to_ms_bus    = exc;
   endtask

   task automatic load_check(input logic [4:0] ld, input logic [1:0] off,
                             input logic [31:0] rd, input logic [31:0] exp);
      drive(1'b1, 1'b1, 1'b1, 5'd7, {30'h400, off}, ld, 7'd0);
      lit_chk = '0;
      tick();
      es_to_ms_valid  = 1'b0;
      data_sram_rdata = rd;
      lit_res = exp; lit_we = 1'b1;
      lit_chk = 6'b1 << L_RES | 6'b1 << L_WE;
      tick();
      lit_chk = '0;
   endtask

   initial begin
      drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 7'd0);
      data_sram_rdata = '0;
      ws_allowin = 1'b1;
      wb_flush = 1'b0;
      #1 resetn = 1'b0;
      lit_vld = 1'b0; lit_alw = 1'b1;
      lit_chk = 6'b1 << L_VLD | 6'b1 << L_ALW | 6'b1 << L_ZERO;
      tick();
      tick();
      resetn = 1'b1;
      lit_chk = '0;

      // Word, byte, half loads
      load_check(5'b00001, 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      load_check(5'b10000, 2'd3, 32'h80FF_0000, 32'hFFFF_FF80);
      load_check(5'b01000, 2'd3, 32'h80FF_0000, 32'h0000_0080);
      load_check(5'b00100, 2'd2, 32'h8001_1234, 32'hFFFF_8001);
      load_check(5'b00010, 2'd0, 32'h8001_F234, 32'h0000_F234);

      // Back-to-back loads each use live read data in their first cycle
      drive(1'b1, 1'b1, 1'b1, 5'd3, 32'h2000, 5'b00001, 7'd0);
      tick();
      drive(1'b1, 1'b1, 1'b1, 5'd4, 32'h2006, 5'b00010, 7'd0);
      data_sram_rdata = 32'h1111_2222;
      lit_res = 32'h1111_2222; lit_chk = 6'b1 << L_RES;
      tick();
      es_to_ms_valid = 1'b0;
      data_sram_rdata = 32'hABCD_0000;
      lit_res = 32'h0000_ABCD;
      tick();
      lit_chk = '0;

      // Stall holds first-cycle data; a waiting payload must not enter
      drive(1'b1, 1'b1, 1'b1, 5'd9, 32'h3000, 5'b00001, 7'd0);
      tick();
      drive(1'b1, 1'b0, 1'b1, 5'd10, 32'h4444, 5'b00000, 7'd0);
      ws_allowin = 1'b0;
      data_sram_rdata = 32'hCAFE_F00D;
      lit_res = 32'hCAFE_F00D; lit_alw = 1'b0; lit_vld = 1'b1;
      lit_chk = 6'b1 << L_RES | 6'b1 << L_ALW | 6'b1 << L_VLD;
      tick();
      data_sram_rdata = 32'h0;
      repeat (3) tick();

      // Flush with an accept in the same cycle: nothing enters
      wb_flush = 1'b1;
      ws_allowin = 1'b1;
      lit_vld = 1'b0; lit_alw = 1'b1;
      lit_chk = 6'b1 << L_VLD | 6'b1 << L_ALW;
      tick();
      wb_flush = 1'b0;
      es_to_ms_valid = 1'b0;
      tick();
      lit_chk = '0;

      // Exception suppresses register write on both outputs
      drive(1'b1, 1'b0, 1'b1, 5'd12, 32'h1234, 5'b00000, 7'b100_0000);
      tick();
      es_to_ms_valid = 1'b0;
      lit_ex = 1'b1; lit_we = 1'b0; lit_res = 32'h1234;
      lit_chk = 6'b1 << L_EX | 6'b1 << L_WE | 6'b1 << L_RES;
      tick();
      lit_chk = '0;

      // Reset during a stall drops valid and buffered data at once
      drive(1'b1, 1'b1, 1'b1, 5'd13, 32'h5000, 5'b00001, 7'd0);
      tick();
      es_to_ms_valid = 1'b0;
      ws_allowin = 1'b0;
      data_sram_rdata = 32'h5555_AAAA;
      tick();
      #1 resetn = 1'b0;
      lit_vld = 1'b0; lit_alw = 1'b1;
      lit_chk = 6'b1 << L_VLD | 6'b1 << L_ALW | 6'b1 << L_ZERO;
      tick();
      resetn = 1'b1;
      ws_allowin = 1'b1;
      lit_chk = '0;

      // Randomised traffic against the model
      for (int i = 0; i < 3000; i++) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               5'($urandom), $urandom, 5'b1 << $urandom_range(0, 4),
               ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'd0);
         data_sram_rdata = $urandom;
         ws_allowin = ($urandom_range(0, 3) != 0);
         wb_flush = ($urandom_range(0, 15) == 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
